// File: rtl/m_pool_pkg.sv
// Shared types and width helpers for the pooling + ReLU stage.
// Optional average datapath is selected by defining POOL_AVG_EN.
package m_pool_pkg;

    typedef enum logic {RUN = 1'b0, DONE = 1'b1} pool_state_t;
    typedef enum logic {MAX = 1'b0, AVG = 1'b1} pool_mode_t;

    // Index width for a 0..n-1 counter, never narrower than one bit
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold the value n itself
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

    // Accumulator width: a full window sum needs log2(win) headroom bits
    function automatic int unsigned acc_w(input int unsigned dw, input int unsigned win,
                                          input bit avg_en);
        return avg_en ? dw + $clog2(win) : dw;
    endfunction

endpackage

// File: rtl/m_pool_acc_bank.sv
// Per-channel accumulator bank with the max / mean datapath and ReLU result.
// Mean pooling is present only when POOL_AVG_EN is defined.
module m_pool_acc_bank
    import m_pool_pkg::*;
#(
    parameter  int unsigned DW  = 16,
    parameter  int unsigned WIN = 16,
    parameter  int unsigned CH  = 1,
    localparam int unsigned IW  = idx_w(CH)
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 upd,
    input  logic                 close,
    input  logic                 avg,
    input  logic [IW-1:0]        idx,
    input  logic signed [DW-1:0] sample,
    output logic signed [DW-1:0] result_c
);

`ifdef POOL_AVG_EN
    localparam bit AVG_EN = 1'b1;
`else
    localparam bit AVG_EN = 1'b0;
`endif
    localparam int unsigned AW = acc_w(DW, WIN, AVG_EN);
    localparam int unsigned SH = $clog2(WIN);

    logic signed [AW-1:0] acc_q [CH];
    logic signed [AW-1:0] cur_c;
    logic signed [AW-1:0] samp_c;
    logic signed [AW-1:0] upd_c;

    // Next entry value and the ReLU'd window result including this sample
    always_comb begin
        cur_c    = acc_q[idx];
        samp_c   = AW'(sample);
        upd_c    = (samp_c > cur_c) ? samp_c : cur_c;
        result_c = DW'(upd_c);
`ifdef POOL_AVG_EN
        if (pool_mode_t'(avg) == AVG) begin
            upd_c    = cur_c + samp_c;
            result_c = upd_c[AW-1] ? '0 : DW'(upd_c >>> SH);
        end
`endif
    end

`ifndef POOL_AVG_EN
    logic unused_avg_c;
    assign unused_avg_c = avg;
`endif

    always_ff @(posedge clk_in or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < CH; i++) acc_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < CH; i++) acc_q[i] <= '0;
        end else if (upd) begin
            acc_q[idx] <= close ? '0 : upd_c;
        end
    end

endmodule

// File: rtl/m_pool_relu_p.sv
// Pooling + ReLU stage: window/channel counters, run/done FSM, output registers.
// Define POOL_AVG_EN to enable mean pooling via avg_mode.
module m_pool_relu_p
    import m_pool_pkg::*;
#(
    parameter int unsigned DW      = 16,
    parameter int unsigned WIN     = 16,
    parameter int unsigned CH      = 1,
    parameter int unsigned NUM_OUT = 484
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] map_in,
    input  logic                 avg_mode,
    output logic signed [DW-1:0] map_out,
    output logic                 wr,
    output logic                 ready
);

    localparam int unsigned IW = idx_w(CH);
    localparam int unsigned WW = idx_w(WIN);
    localparam int unsigned OW = cnt_w(NUM_OUT);

    pool_state_t          state_q, state_d;
    logic [IW-1:0]        ch_q, ch_d;
    logic [WW-1:0]        win_q, win_d;
    logic [OW-1:0]        out_q, out_d;
    logic                 wr_d, ready_d;
    logic signed [DW-1:0] map_d, res_c;
    logic                 full_c, accept_c, close_c;

    m_pool_acc_bank #(.DW(DW), .WIN(WIN), .CH(CH)) u_bank (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .clr      (clr),
        .upd      (accept_c),
        .close    (close_c),
        .avg      (avg_mode),
        .idx      (ch_q),
        .sample   (map_in),
        .result_c (res_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        full_c   = (out_q == OW'(NUM_OUT));
        accept_c = in_valid && !clr && (state_q == RUN) && !full_c;
        close_c  = accept_c && (win_q == WW'(WIN - 1));
        state_d  = state_q;
        ch_d     = ch_q;
        win_d    = win_q;
        out_d    = out_q;
        wr_d     = 1'b0;
        map_d    = map_out;
        ready_d  = !full_c;
        if (clr) begin
            state_d = RUN;
            ch_d    = '0;
            win_d   = '0;
            out_d   = '0;
            ready_d = 1'b1;
        end else begin
            if (full_c) state_d = DONE;
            if (accept_c) begin
                if (ch_q == IW'(CH - 1)) begin
                    ch_d  = '0;
                    win_d = (win_q == WW'(WIN - 1)) ? '0 : win_q + WW'(1);
                end else begin
                    ch_d = ch_q + IW'(1);
                end
                if (close_c) begin
                    wr_d  = 1'b1;
                    map_d = res_c;
                    out_d = out_q + OW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_n) begin
        if (rst_n) begin
            state_q <= RUN;
            ch_q    <= '0;
            win_q   <= '0;
            out_q   <= '0;
            wr      <= 1'b0;
            map_out <= '0;
            ready   <= 1'b1;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            win_q   <= win_d;
            out_q   <= out_d;
            wr      <= wr_d;
            map_out <= map_d;
            ready   <= ready_d;
        end
    end

endmodule

// File: tb/tb_m_pool_relu_p.sv
// Scoreboard bench for m_pool_relu_p (WIN=4, CH=2, NUM_OUT=5); mean pooling
// is exercised as well when POOL_AVG_EN is defined.
module tb_m_pool_relu_p;

    localparam int unsigned DW      = 16;
    localparam int unsigned WIN     = 4;
    localparam int unsigned CH      = 2;
    localparam int unsigned NUM_OUT = 5;

    logic                 clk_in   = 1'b0;
    logic                 rst      = 1'b1;
    logic                 clr      = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 avg_mode = 1'b0;
    logic signed [DW-1:0] map_in   = '0;
    logic signed [DW-1:0] map_out;
    logic                 wr;
    logic                 ready;

    always #5 clk_in = ~clk_in;

    m_pool_relu_p #(.DW(DW), .WIN(WIN), .CH(CH), .NUM_OUT(NUM_OUT)) dut (
        .clk_in   (clk_in),
        .rst_n    (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .map_in   (map_in),
        .avg_mode (avg_mode),
        .map_out  (map_out),
        .wr       (wr),
        .ready    (ready)
    );

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference model: per-channel sample buffers and output count
    int   wbuf [CH][WIN];
    int   wcnt [CH];
    int   m_ch;
    int   m_cnt;
    bit   m_avg     = 1'b0;
    bit   exp_ready = 1'b1;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ref_result(input int c);
        int r = 0;
        int s = 0;
        for (int i = 0; i < WIN; i++) begin
            s += wbuf[c][i];
            if (wbuf[c][i] > r) r = wbuf[c][i];
        end
        if (m_avg) r = (s < 0) ? 0 : s / int'(WIN);
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < CH; i++) wcnt[i] = 0;
        m_ch  = 0;
        m_cnt = 0;
    endtask

    task automatic set_mode(input bit a);
        avg_mode = a;
`ifdef POOL_AVG_EN
        m_avg = a;
`else
        m_avg = 1'b0;
`endif
    endtask

    // One clock of stimulus; ready is checked against the prior cycle's model
    task automatic step(input bit v, input int d, input bit c);
        @(negedge clk_in);
        check("ready", ready, exp_ready);
        in_valid = v;
        map_in   = DW'(d);
        clr      = c;
        if (c) begin
            model_clear();
            exp_ready = 1'b1;
            return;
        end
        exp_ready = (m_cnt != NUM_OUT);
        if (v && m_cnt != NUM_OUT) begin
            wbuf[m_ch][wcnt[m_ch]] = d;
            wcnt[m_ch]++;
            if (wcnt[m_ch] == WIN) begin
                exp_q.push_back('{ref_result(m_ch), cyc + 1});
                wcnt[m_ch] = 0;
                m_cnt++;
            end
            m_ch = (m_ch + 1) % CH;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst      = 1'b1;
        in_valid = 1'b0;
        clr      = 1'b0;
        model_clear();
        exp_ready = 1'b1;
        @(negedge clk_in);
        check("reset_wr", wr, 0);
        check("reset_ready", ready, 1);
        rst = 1'b0;
    endtask

    // Monitor: every output strobe must match the next expected result and cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (!rst && wr) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_wr: got map_out %0d expected no strobe (cycle %0d)",
                             map_out, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("map_out", map_out, e.data);
                    check("wr_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        logic signed [DW-1:0] rnd;
        model_clear();
        repeat (2) @(negedge clk_in);
        check("reset_map_out", map_out, 0);
        check("reset_wr", wr, 0);
        check("reset_ready", ready, 1);
        rst = 1'b0;

        // Max pooling with ReLU: ch0 -> 7, ch1 (all negative) -> 0, back to back
        set_mode(1'b0);
        step(1, 3, 0);  step(1, -1, 0); step(1, -5, 0); step(1, -2, 0);
        step(1, 7, 0);  step(1, -3, 0); step(1, 2, 0);  step(1, -4, 0);

        // Gap of 3 idle cycles mid-window leaves the partial window intact
        step(1, 10, 0); step(1, -7, 0);
        repeat (3) step(0, 999, 0);
        step(1, 20, 0); step(1, -6, 0); step(1, 15, 0); step(1, -9, 0);
        step(1, 4, 0);  step(1, -1, 0);

        // Fifth output ends the layer; ch1's partial window is discarded
        step(1, 11, 0); step(1, 12, 0); step(1, 13, 0); step(1, 14, 0);
        step(1, 15, 0); step(1, 16, 0); step(1, 17, 0);
        repeat (10) step(1, 500, 0);

        // Restart, then reset after two samples; pre-reset data must vanish
        step(0, 0, 1);
        step(1, 30000, 0); step(1, 30000, 0);
        do_reset();
        for (int i = 0; i < 2 * WIN; i++) step(1, i - 3, 0);
        step(0, 0, 0);

`ifdef POOL_AVG_EN
        // Mean pooling: ch0 sum 16 -> 4, ch1 sum -8 -> 0
        set_mode(1'b1);
        step(0, 0, 1);
        step(1, 4, 0);  step(1, -4, 0); step(1, 8, 0); step(1, -4, 0);
        step(1, -2, 0); step(1, 0, 0);  step(1, 6, 0); step(1, 0, 0);
`endif

        // Random layers; a sample offered together with clr is dropped
        for (int layer = 0; layer < 8; layer++) begin
            set_mode(1'($urandom_range(0, 1)));
            step(1, 32000, 1);
            for (int k = 0; k < 60; k++) begin
                rnd = DW'($urandom);
                if (layer % 2 == 1) rnd = DW'($urandom_range(0, 20)) - DW'(10);
                step($urandom_range(0, 9) < 7, int'(rnd), 0);
            end
        end

        repeat (4) step(0, 0, 0);
        check("drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/m_pool_relu_p.md
# m_pool_relu_p

Parametrised pooling + ReLU stage following each convolution layer in the CNN pipeline. Accepts a stream of signed conv results, interleaved over CH channels, reduces each non-overlapping WIN-sample window per channel to max(0, max) (or ReLU of the mean, when compiled in), and emits one write strobe per pooled value toward the next layer's RAM. It counts outputs and drops `ready` once the layer's map is complete.

## Interface
- `DW`, 16: sample and result width, signed two's complement.
- `WIN`, 16: samples per pooling window per channel, ≥2; must be a power of two when averaging is compiled in.
- `CH`, 1: number of interleaved channels, ≥1.
- `NUM_OUT`, 484: total pooled outputs, all channels, per layer.
- `clk_in` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-high despite the name.
- `clr` input 1: synchronous restart for the next layer.
- `in_valid` input 1: `map_in` valid this cycle.
- `map_in` input DW: signed sample; channel = arrival index mod CH.
- `avg_mode` input 1: 0 = max pooling, 1 = average pooling; honoured only with `POOL_AVG_EN`.
- `map_out` output DW: signed pooled result, held between strobes.
- `wr` output 1: one-cycle strobe, `map_out` valid.
- `ready` output 1: high while the layer is incomplete.

## Operation
- Two states:
  - RUN: accepts samples.
  - DONE: entered when `out_cnt` reaches NUM_OUT; ignores `in_valid` and keeps `wr` = 0.
  - `clr` in either state returns to RUN with all counters and accumulators cleared.
- Counters advance only on accepted samples (`in_valid` = 1 in RUN):
  - `ch_cnt` (0..CH-1) wraps to 0.
  - `win_cnt` (0..WIN-1) increments on the `ch_cnt` wrap and itself wraps.
  - `out_cnt` width is clog2(NUM_OUT+1).
- Per-channel accumulator bank, CH entries; the current entry is indexed by `ch_cnt`:
  - Max mode: entry resets to 0, so ReLU is implicit. On each sample, entry <= (map_in > entry) ? map_in : entry, signed compare.
  - Avg mode: entry is a DW+log2(WIN)-bit signed sum.
- Window close: the sample arriving with `win_cnt` = WIN-1 closes its channel's window.
  - Result is computed including that sample.
  - `map_out` <= result, `wr` <= 1, `out_cnt` += 1, entry <= 0.
- Avg result: if sum < 0 the result is 0; otherwise sum >> log2(WIN), truncating. This cannot overflow DW.
- `in_valid` = 0 in RUN: all state holds; a partial window is retained indefinitely.
- `clr` and `in_valid` in the same cycle: `clr` wins and the sample is dropped.
- `rst_n` mid-window: all state discarded immediately, no output.
- NUM_OUT not a multiple of CH: DONE is still entered exactly at NUM_OUT; the remaining partial windows are discarded.

## Timing
- Reset values: `map_out` = 0, `wr` = 0, `ready` = 1, state RUN, all counters and accumulators 0.
- Latency: `wr` and `map_out` update on the same clock edge that samples the window-closing input, i.e. visible in the following cycle.
- With CH > 1 and continuous input, the CH closing samples are consecutive, so `wr` is high for CH consecutive cycles.
- `ready` is registered from `out_cnt`. The edge asserting the final `wr` sets `out_cnt` = NUM_OUT; `ready` falls on the next edge.
- Input gating uses `out_cnt`, not `ready`.
- `ready` returns to 1 on the edge after `clr`.

## Configuration
- `POOL_AVG_EN`, defined: average datapath and `avg_mode` are active, and the accumulator is widened to DW+log2(WIN).
- `POOL_AVG_EN`, undefined: max-only datapath, `avg_mode` ignored, accumulator is DW bits. Behaviour must be identical to avg_mode = 0 in the enabled build.

## Structure
- Package `m_pool_pkg`: `pool_state_t` (RUN, DONE), `pool_mode_t` (MAX, AVG), and clog2-based width helpers for counters and accumulators.
- One sub-module, `m_pool_acc_bank`: CH-entry accumulator register file with a read/update/clear port and the max/sum datapath. The top holds counters, the FSM, and the output registers.

## Test plan
- WIN=4, CH=1, max mode; inputs 3, -5, 7, 2 -> single `wr` pulse one cycle after the 4th sample, `map_out` = 7.
- WIN=4, CH=1; inputs -1, -2, -3, -4 -> `map_out` = 0, with `wr` pulsed.
- WIN=2, CH=2; inputs 5, -9, 1, 8 -> `wr` on two consecutive cycles, `map_out` = 5 then 8.
- `POOL_AVG_EN`, avg_mode=1, WIN=4:
  - 4, 8, -2, 6 -> `map_out` = 4.
  - -4, -4, 0, 0 -> `map_out` = 0.
- WIN=4, NUM_OUT=2, `in_valid` low for 3 cycles mid-window:
  - Window results are unchanged by the gap.
  - `ready` falls one cycle after the 2nd `wr`.
  - Further samples produce no `wr`.
  - `clr` -> `ready` = 1 and a fresh window is accepted.
- `rst_n` pulsed after 2 of 4 samples -> no `wr`. The next 4 samples form a fresh window whose result ignores the pre-reset data.
